// File: rtl/led_pkg.sv
// Shared constants and types for the LED blink path (divider controller and LED counter).
package led_pkg;

  localparam logic [4:0]  DIV_MIN = 5'd1;
  localparam logic [4:0]  DIV_MAX = 5'd20;
  localparam logic [27:0] CNT_1S  = 28'h5F5E100;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } btn_state_t;

  // Width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one raw button, pulsing press_evt once per accepted press.
// Auto-repeat while held is compiled in with LED_DIV_AUTOREPEAT_EN.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int REPEAT_CYC   = 50_000_000
) (
  input  logic clk100,
  input  logic rst,
  input  logic btn,
  output logic press_evt
);

  localparam int CW = cnt_w(DEBOUNCE_CYC);

  if (DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE_CYC and REPEAT_CYC must be at least 1");
  end

  logic [1:0]    sync;
  logic          level;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic          rpt_evt;

  always_ff @(posedge clk100) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], btn};
  end

  assign level    = sync[1];
  assign cnt_done = (cnt == CW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk100) begin
    if (rst) state <= RELEASED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RELEASED:    if (level) state_nxt = PRESS_CHK;
      PRESS_CHK:   if (!level) state_nxt = RELEASED;
                   else if (cnt_done) state_nxt = PRESSED;
      PRESSED:     if (!level) state_nxt = RELEASE_CHK;
      RELEASE_CHK: if (level) state_nxt = PRESSED;
                   else if (cnt_done) state_nxt = RELEASED;
      default:     state_nxt = RELEASED;
    endcase
  end

  // Every transition clears the count, so it never runs past DEBOUNCE_CYC-1.
  always_ff @(posedge clk100) begin
    if (rst)
      cnt <= '0;
    else if (state_nxt != state)
      cnt <= '0;
    else if (state == PRESS_CHK || state == RELEASE_CHK)
      cnt <= cnt + 1'b1;
  end

`ifdef LED_DIV_AUTOREPEAT_EN
  localparam int RW = cnt_w(REPEAT_CYC);

  logic [RW-1:0] rpt;
  logic          rpt_done;

  assign rpt_done = (rpt == RW'(REPEAT_CYC - 1));
  assign rpt_evt  = (state == PRESSED) && rpt_done;

  // Cleared only on a fresh press; a bounce back from RELEASE_CHK resumes the count.
  always_ff @(posedge clk100) begin
    if (rst)
      rpt <= '0;
    else if (state == PRESS_CHK && state_nxt == PRESSED)
      rpt <= '0;
    else if (state == PRESSED)
      rpt <= rpt_done ? '0 : rpt + 1'b1;
  end
`else
  assign rpt_evt = 1'b0;
`endif

  always_comb begin
    press_evt = (state == PRESS_CHK && level && cnt_done) || rpt_evt;
  end

endmodule

// File: rtl/led_div_ctrl.sv
// Up/down pushbutton stepping of the LED blink divider (1..20) with a write strobe per change.
// Auto-repeat while a button is held is compiled in with LED_DIV_AUTOREPEAT_EN.
module led_div_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int REPEAT_CYC   = 50_000_000,
  parameter int DIV_INIT     = 3
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  output logic [4:0] div_o,
  output logic       wren_o
);

  if (DIV_INIT < int'(DIV_MIN) || DIV_INIT > int'(DIV_MAX)) begin : g_bad_init
    $error("led_div_ctrl: DIV_INIT out of range");
  end

  logic       up_evt;
  logic       dn_evt;
  logic [4:0] div_nxt;
  logic       step;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_CYC  (REPEAT_CYC)
  ) u_btn_up (
    .clk100   (clk100),
    .rst      (rst),
    .btn      (btn_up_i),
    .press_evt(up_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_CYC  (REPEAT_CYC)
  ) u_btn_dn (
    .clk100   (clk100),
    .rst      (rst),
    .btn      (btn_dn_i),
    .press_evt(dn_evt)
  );

  // Range check before the add/subtract keeps 5-bit arithmetic from wrapping.
  always_comb begin
    div_nxt = div_o;
    step    = 1'b0;
    if (up_evt && !dn_evt && div_o < DIV_MAX) begin
      div_nxt = div_o + 5'd1;
      step    = 1'b1;
    end else if (dn_evt && !up_evt && div_o > DIV_MIN) begin
      div_nxt = div_o - 5'd1;
      step    = 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      div_o  <= 5'(DIV_INIT);
      wren_o <= 1'b0;
    end else begin
      div_o  <= div_nxt;
      wren_o <= step;
    end
  end

endmodule
